param_demux_regbank: RTL and testbench
======================================

// Module: param_demux_regbank
// PURPOSE
//  Write-side counterpart of param_mux: decodes a select into a one-hot enable and
//  stores data into one of NUM_REGS registers, exposing the full array for
//  param_mux read ports. Serves as the RV32I register-file write port:
//  valid/ready write handshake, hardwired-zero entry 0 and a sequential clear sweep.
// PARAMETERS
//  DATA_WIDTH  32                  width of each register
//  NUM_REGS    32                  number of registers (power of 2, >=2)
//  SEL_WIDTH   $clog2(NUM_REGS)    select/address width
//  ZERO_REG    1                   1: entry 0 reads 0 and ignores writes
// PORTS
//  clk         in   1                      clock, rising edge
//  rst         in   1                      synchronous reset, active-high
//  i_wr_valid  in   1                      write request
//  o_wr_ready  out  1                      bank can accept a write this cycle
//  i_wr_sel    in   SEL_WIDTH              destination register index
//  i_wr_data   in   DATA_WIDTH             write data
//  i_clear     in   1                      start clear sweep (1-cycle pulse)
//  o_regs      out  NUM_REGS x DATA_WIDTH  register array; feeds param_mux i_mux
//  o_wr_onehot out  NUM_REGS               registered one-hot of the last accepted write
//  o_written   out  NUM_REGS               sticky mask: entry written since reset/clear
//  o_busy      out  1                      clear sweep in progress
// BEHAVIOUR
//  - Reset (rst=1 at posedge): all o_regs=0, o_wr_onehot=0, o_written=0,
//    state=IDLE, sweep counter=0, o_busy=0, o_wr_ready=1 in the following cycle.
//  - FSM states: IDLE, CLEAR.
//    IDLE -> CLEAR when i_clear=1; CLEAR -> IDLE after the write of index NUM_REGS-1.
//  - o_wr_ready = (state==IDLE) && !i_clear (combinational). o_busy = (state==CLEAR).
//  - Write accepted on the posedge where i_wr_valid && o_wr_ready. Latency 1: o_regs[sel]
//    holds i_wr_data from the next cycle. No read-during-write bypass.
//  - Decode: enable[k] = (i_wr_sel==k) && accept. Exactly one entry changes per accept.
//  - Accepted write: o_wr_onehot <= enable and o_written[sel] <= 1. Any cycle without an
//    accept: o_wr_onehot <= 0.
//  - ZERO_REG=1 and sel=0: handshake still completes (ready honoured); o_regs[0] stays 0;
//    o_wr_onehot[0] <= 1; o_written[0] is not set.
//  - Held i_wr_valid while ready=0: no write; the request is stalled, not dropped.
//    The requester keeps valid, sel and data stable until accepted.
//  - CLEAR: one register per cycle, index 0..NUM_REGS-1, zeroed via counter. Takes
//    exactly NUM_REGS cycles, then IDLE. o_written <= 0 on entry to CLEAR.
//    o_wr_onehot stays 0 throughout.
//  - i_clear and i_wr_valid in the same IDLE cycle: clear wins and the write is not
//    accepted (ready=0). i_clear while already in CLEAR is ignored; the sweep is not
//    restarted.
//  - rst during CLEAR: immediate full reset, as above. rst overrides all inputs.
//  - Counter width SEL_WIDTH; terminal count NUM_REGS-1 compared explicitly, so no
//    wrap dependence.
// TESTING
//  1. Reset, then write sel=5,data=0xDEADBEEF -> next cycle o_regs[5]=0xDEADBEEF,
//     o_wr_onehot=1<<5, o_written=1<<5, all other o_regs=0.
//  2. Write sel=0 data=0x12345678 (ZERO_REG=1) -> o_regs[0]=0, o_wr_onehot=1,
//     o_written[0]=0. Mux select 0 on o_regs returns 0.
//  3. Write all 32 entries with data=i, then drive param_mux select 0,5,7,31 ->
//     outputs 0,5,7,31.
//  4. Pulse i_clear with i_wr_valid=1 (sel=3) -> write dropped, o_busy=1 for exactly
//     32 cycles, all o_regs=0, o_written=0. o_wr_ready returns to 1 on cycle 33.
//  5. Hold i_wr_valid (sel=9,data=0xA5) through a clear -> o_regs[9]=0xA5 one cycle
//     after o_busy falls. No earlier write.
//  6. Assert rst at cycle 10 of a clear sweep -> next cycle o_busy=0, o_wr_ready=1,
//     all outputs 0.

Source files
------------

// File: rtl/param_demux_regbank.sv
// -----------------------------------------------------------------------------
// param_demux_regbank
//
// Write side of a parameterised register bank. A destination select is decoded
// into a one-hot enable and the write data lands in exactly one register. The
// whole array is exposed in parallel so that param_mux instances can build the
// read ports. As an RV32I register file write port it provides:
//   - a valid/ready write handshake,
//   - an optional hardwired-zero entry 0,
//   - a sequential clear sweep that zeroes one entry per cycle.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous reset, active high, overrides every other input
//   i_wr_valid   write request
//   o_wr_ready   bank can accept a write this cycle (combinational)
//   i_wr_sel     destination register index
//   i_wr_data    write data
//   i_clear      one-cycle pulse that starts a clear sweep
//   o_regs       full register array, entry k at o_regs[k]
//   o_wr_onehot  registered one-hot of the write accepted on the previous edge
//   o_written    sticky mask of entries written since the last reset or clear
//   o_busy       clear sweep in progress
// -----------------------------------------------------------------------------
module param_demux_regbank #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 32,
    parameter int SEL_WIDTH  = $clog2(NUM_REGS),
    parameter int ZERO_REG   = 1
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 i_wr_valid,
    output logic                                 o_wr_ready,
    input  logic [SEL_WIDTH-1:0]                 i_wr_sel,
    input  logic [DATA_WIDTH-1:0]                i_wr_data,
    input  logic                                 i_clear,
    output logic [NUM_REGS-1:0][DATA_WIDTH-1:0]  o_regs,
    output logic [NUM_REGS-1:0]                  o_wr_onehot,
    output logic [NUM_REGS-1:0]                  o_written,
    output logic                                 o_busy
);

    // Terminal count of the sweep, compared explicitly so the counter never
    // relies on wrapping back to zero.
    localparam logic [SEL_WIDTH-1:0] LAST_IDX = SEL_WIDTH'(NUM_REGS - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t                 state_reg;
    state_t                 state_next;
    logic [SEL_WIDTH-1:0]   sweep_cnt_reg;
    logic [SEL_WIDTH-1:0]   sweep_cnt_next;

    logic                   accept;
    logic                   clear_start;
    logic [NUM_REGS-1:0]    wr_en;
    logic [NUM_REGS-1:0]    wr_onehot_reg;

    // -------------------------------------------------------------------------
    // Handshake
    // -------------------------------------------------------------------------
    // A clear request in IDLE takes priority over a simultaneous write: ready
    // drops in that same cycle so the requester holds its write until the
    // sweep has finished.
    assign o_wr_ready  = (state_reg == ST_IDLE) && !i_clear;
    assign o_busy      = (state_reg == ST_CLEAR);
    assign accept      = i_wr_valid && o_wr_ready;
    assign clear_start = (state_reg == ST_IDLE) && i_clear;

    // -------------------------------------------------------------------------
    // Sweep FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            sweep_cnt_reg <= '0;
        end else begin
            state_reg     <= state_next;
            sweep_cnt_reg <= sweep_cnt_next;
        end
    end

    // -------------------------------------------------------------------------
    // Sweep FSM: next state. i_clear is not looked at in CLEAR, so a second
    // pulse during a sweep does not restart it.
    // -------------------------------------------------------------------------
    always_comb begin
        state_next     = state_reg;
        sweep_cnt_next = sweep_cnt_reg;
        case (state_reg)
            ST_IDLE: begin
                if (i_clear) begin
                    state_next     = ST_CLEAR;
                    sweep_cnt_next = '0;
                end
            end
            ST_CLEAR: begin
                if (sweep_cnt_reg == LAST_IDX) begin
                    state_next     = ST_IDLE;
                    sweep_cnt_next = '0;
                end else begin
                    sweep_cnt_next = sweep_cnt_reg + 1'b1;
                end
            end
            default: begin
                state_next     = ST_IDLE;
                sweep_cnt_next = '0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Per-entry decode and storage
    // -------------------------------------------------------------------------
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_entry
        // The enable includes the handshake, so at most one bit is ever set.
        assign wr_en[gi] = accept && (i_wr_sel == SEL_WIDTH'(gi));

        if ((ZERO_REG != 0) && (gi == 0)) begin : g_zero
            // Hardwired zero: writes still complete the handshake and show
            // up in o_wr_onehot, but neither data nor the written flag stick.
            assign o_regs[gi]    = '0;
            assign o_written[gi] = 1'b0;
        end else begin : g_store
            logic [DATA_WIDTH-1:0] data_reg;
            logic                  written_reg;
            logic                  sweep_hit;

            assign sweep_hit = o_busy && (sweep_cnt_reg == SEL_WIDTH'(gi));

            // Writes and sweep hits never coincide: ready is low in CLEAR.
            always_ff @(posedge clk) begin
                if (rst) begin
                    data_reg <= '0;
                end else if (sweep_hit) begin
                    data_reg <= '0;
                end else if (wr_en[gi]) begin
                    data_reg <= i_wr_data;
                end
            end

            // The whole mask drops on entry to CLEAR, not entry by entry.
            always_ff @(posedge clk) begin
                if (rst) begin
                    written_reg <= 1'b0;
                end else if (clear_start) begin
                    written_reg <= 1'b0;
                end else if (wr_en[gi]) begin
                    written_reg <= 1'b1;
                end
            end

            assign o_regs[gi]    = data_reg;
            assign o_written[gi] = written_reg;
        end
    end

    // -------------------------------------------------------------------------
    // Last-accepted-write indicator. wr_en is all zero whenever nothing is
    // accepted (including the whole sweep), so the register self-clears.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_onehot_reg <= '0;
        end else begin
            wr_onehot_reg <= wr_en;
        end
    end

    assign o_wr_onehot = wr_onehot_reg;

endmodule

// File: tb/tb_param_demux_regbank.sv
// -----------------------------------------------------------------------------
// tb_param_demux_regbank
// Directed bench for param_demux_regbank with DATA_WIDTH=32, NUM_REGS=32,
// ZERO_REG=1. Inputs change 1 ns after a rising edge; outputs are checked at
// that same point, i.e. well away from the next active edge.
// -----------------------------------------------------------------------------
module tb_param_demux_regbank;

    localparam int DW = 32;
    localparam int NR = 32;
    localparam int SW = 5;

    logic                    clk;
    logic                    rst;
    logic                    i_wr_valid;
    logic                    o_wr_ready;
    logic [SW-1:0]           i_wr_sel;
    logic [DW-1:0]           i_wr_data;
    logic                    i_clear;
    logic [NR-1:0][DW-1:0]   o_regs;
    logic [NR-1:0]           o_wr_onehot;
    logic [NR-1:0]           o_written;
    logic                    o_busy;

    int total = 0;
    int bad   = 0;

    param_demux_regbank #(
        .DATA_WIDTH (DW),
        .NUM_REGS   (NR),
        .SEL_WIDTH  (SW),
        .ZERO_REG   (1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_wr_valid  (i_wr_valid),
        .o_wr_ready  (o_wr_ready),
        .i_wr_sel    (i_wr_sel),
        .i_wr_data   (i_wr_data),
        .i_clear     (i_clear),
        .o_regs      (o_regs),
        .o_wr_onehot (o_wr_onehot),
        .o_written   (o_written),
        .o_busy      (o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", name, obs, exp);
        end
        $display("check %-22s observed=0x%0h expected=0x%0h", name, obs, exp);
    endtask

    // One bit per entry that is non-zero; expected to be all clear.
    function automatic logic [NR-1:0] nonzero_mask();
        logic [NR-1:0] m;
        m = '0;
        for (int k = 0; k < NR; k++) m[k] = |o_regs[k];
        return m;
    endfunction

    task automatic do_write(input logic [SW-1:0] sel, input logic [DW-1:0] data);
        i_wr_valid = 1'b1;
        i_wr_sel   = sel;
        i_wr_data  = data;
        tick();
        i_wr_valid = 1'b0;
    endtask

    int  busy_cycles;
    bit  early_write;

    initial begin
        rst        = 1'b1;
        i_wr_valid = 1'b0;
        i_wr_sel   = '0;
        i_wr_data  = '0;
        i_clear    = 1'b0;

        // ---------------- reset ----------------
        tick();
        tick();
        rst = 1'b0;
        chk("rst_regs_nonzero", 64'(nonzero_mask()), 64'h0);
        chk("rst_onehot",       64'(o_wr_onehot),    64'h0);
        chk("rst_written",      64'(o_written),      64'h0);
        chk("rst_busy",         64'(o_busy),         64'h0);
        chk("rst_ready",        64'(o_wr_ready),     64'h1);

        // ---------------- 1: single write ----------------
        do_write(5'd5, 32'hDEADBEEF);
        chk("t1_reg5",    64'(o_regs[5]),   64'hDEADBEEF);
        chk("t1_onehot",  64'(o_wr_onehot), 64'h20);
        chk("t1_written", 64'(o_written),   64'h20);
        chk("t1_others",  64'(nonzero_mask()), 64'h20);
        tick();
        chk("t1_onehot_idle", 64'(o_wr_onehot), 64'h0);

        // ---------------- 2: hardwired zero ----------------
        do_write(5'd0, 32'h12345678);
        chk("t2_reg0",    64'(o_regs[0]),   64'h0);
        chk("t2_onehot",  64'(o_wr_onehot), 64'h1);
        chk("t2_written", 64'(o_written),   64'h20);

        // ---------------- 3: fill all entries with their index ----------------
        for (int i = 0; i < NR; i++) do_write(SW'(i), DW'(i));
        chk("t3_onehot_last", 64'(o_wr_onehot), 64'h8000_0000);
        chk("t3_mux_sel0",    64'(o_regs[0]),   64'd0);
        chk("t3_mux_sel5",    64'(o_regs[5]),   64'd5);
        chk("t3_mux_sel7",    64'(o_regs[7]),   64'd7);
        chk("t3_mux_sel31",   64'(o_regs[31]),  64'd31);
        chk("t3_written",     64'(o_written),   64'hFFFF_FFFE);

        // ---------------- 4: clear wins over a same-cycle write ----------------
        i_clear    = 1'b1;
        i_wr_valid = 1'b1;
        i_wr_sel   = 5'd3;
        i_wr_data  = 32'h77;
        #1;
        chk("t4_ready_low", 64'(o_wr_ready), 64'h0);
        tick();
        i_clear    = 1'b0;
        i_wr_valid = 1'b0;
        chk("t4_busy",         64'(o_busy),      64'h1);
        chk("t4_reg3_kept",    64'(o_regs[3]),   64'd3);
        chk("t4_written_zero", 64'(o_written),   64'h0);
        busy_cycles = 0;
        // Sweep order: after 5 more edges entries 0..4 are cleared, 5.. remain.
        for (int c = 0; c < 5; c++) begin
            busy_cycles += int'(o_busy);
            tick();
        end
        chk("t4_mid_reg4", 64'(o_regs[4]), 64'd0);
        chk("t4_mid_reg5", 64'(o_regs[5]), 64'd5);
        // A clear pulse mid-sweep is ignored and must not lengthen it.
        i_clear = 1'b1;
        busy_cycles += int'(o_busy);
        tick();
        i_clear = 1'b0;
        for (int c = 0; c < 40 && o_busy; c++) begin
            busy_cycles++;
            tick();
        end
        chk("t4_busy_cycles", 64'(busy_cycles),    64'd32);
        chk("t4_ready_back",  64'(o_wr_ready),     64'h1);
        chk("t4_regs_zero",   64'(nonzero_mask()), 64'h0);
        chk("t4_written_end", 64'(o_written),      64'h0);
        chk("t4_onehot_end",  64'(o_wr_onehot),    64'h0);

        // ---------------- 5: write held across a clear ----------------
        do_write(5'd9, 32'h11);
        chk("t5_pre_reg9", 64'(o_regs[9]), 64'h11);
        i_clear    = 1'b1;
        i_wr_valid = 1'b1;
        i_wr_sel   = 5'd9;
        i_wr_data  = 32'hA5;
        tick();
        i_clear     = 1'b0;
        early_write = 1'b0;
        for (int c = 0; c < 40 && o_busy; c++) begin
            if (o_regs[9] == 32'hA5 || o_wr_onehot != '0) early_write = 1'b1;
            tick();
        end
        chk("t5_no_early_write", 64'(early_write), 64'h0);
        chk("t5_busy_fell",      64'(o_busy),      64'h0);
        chk("t5_reg9_swept",     64'(o_regs[9]),   64'h0);
        chk("t5_ready",          64'(o_wr_ready),  64'h1);
        tick();
        i_wr_valid = 1'b0;
        chk("t5_reg9_written",   64'(o_regs[9]),   64'hA5);
        chk("t5_onehot",         64'(o_wr_onehot), 64'h200);
        chk("t5_written",        64'(o_written),   64'h200);

        // ---------------- 6: reset in the middle of a sweep ----------------
        do_write(5'd20, 32'hCAFE);
        chk("t6_pre_reg20", 64'(o_regs[20]), 64'hCAFE);
        i_clear = 1'b1;
        tick();
        i_clear = 1'b0;
        for (int c = 0; c < 9; c++) tick();
        chk("t6_busy_c10", 64'(o_busy), 64'h1);
        rst        = 1'b1;
        i_wr_valid = 1'b1;
        i_wr_sel   = 5'd4;
        i_wr_data  = 32'h55;
        tick();
        rst        = 1'b0;
        i_wr_valid = 1'b0;
        chk("t6_busy",      64'(o_busy),         64'h0);
        chk("t6_ready",     64'(o_wr_ready),     64'h1);
        chk("t6_regs_zero", 64'(nonzero_mask()), 64'h0);
        chk("t6_onehot",    64'(o_wr_onehot),    64'h0);
        chk("t6_written",   64'(o_written),      64'h0);
        do_write(5'd1, 32'h1);
        chk("t6_post_reg1", 64'(o_regs[1]), 64'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
